// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   XLEN        : datapath width
//   REG_ADDR_W  : register address width
//   wb_req_t    : one pending register-file write (destination + data)
//   rd_onehot() : one-hot decode of a destination register
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return 32'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular FIFO buffering long-latency results until a write slot is free.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears pointers/valids)
//   push         : write push_req at the tail (caller guarantees !full)
//   push_req     : entry to store
//   pop          : retire the head entry (caller guarantees !empty)
//   head         : oldest entry
//   full, empty  : occupancy flags from the registered count
//   count        : number of valid entries
//   entry_valid  : per-slot valid bit
//   entry_rd     : per-slot destination register (meaningful where valid)
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_req_t                          push_req,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  wb_req_t         mem [DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; validity is tracked by entry_valid and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_req;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd[i] = mem[i].rd;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == ($clog2(DEPTH) + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB
// stage and buffered long-latency-unit (LU) results. LU results are written in
// idle WB slots; a head entry that waits STARVE_MAX cycles forces a one-cycle
// pipeline stall to drain it. pending_mask_out flags destinations still
// buffered so issue can detect hazards.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   wb_rd_in/wb_data_in/wb_wr_in      : WB stage write request
//   lu_valid_in/lu_rd_in/lu_data_in   : LU result offer
//   lu_ready_out                      : FIFO can accept an LU result
//   rf_wr_out/rf_rd_out/rf_data_out   : register-file write port
//   pipe_stall_out                    : freeze MEM/WB (WB request repeats next cycle)
//   pending_mask_out                  : bit i set if a buffered entry targets x<i>
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      wb_rd_in,
  input  logic [XLEN-1:0] wb_data_in,
  input  logic            wb_wr_in,
  input  logic            lu_valid_in,
  input  logic [4:0]      lu_rd_in,
  input  logic [XLEN-1:0] lu_data_in,
  output logic            lu_ready_out,
  output logic            rf_wr_out,
  output logic [4:0]      rf_rd_out,
  output logic [XLEN-1:0] rf_data_out,
  output logic            pipe_stall_out,
  output logic [31:0]     pending_mask_out
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  wb_req_t                          head;
  wb_req_t                          push_req;
  logic                             full;
  logic                             empty;
  logic [$clog2(DEPTH):0]           count;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
  logic                             push;
  logic                             pop;
  logic                             pipe_need;
  logic                             starved;
  logic                             grant_fifo;
  logic                             grant_wb;
  logic [CntW-1:0]                  wait_cnt;
  logic [31:0]                      mask;

  assign push_req = '{rd: lu_rd_in, data: lu_data_in};

  // rd==0 results are acknowledged but never stored: x0 is not writable.
  assign push = !rst && lu_valid_in && !full && (lu_rd_in != 5'd0);

  assign pipe_need  = wb_wr_in && (wb_rd_in != 5'd0);
  assign starved    = !empty && (wait_cnt >= CntW'(STARVE_MAX));
  assign grant_fifo = !rst && !empty && (starved || !pipe_need);
  assign grant_wb   = !rst && !starved && pipe_need;
  assign pop        = grant_fifo;

  wb_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_req   (push_req),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .entry_valid(entry_valid),
    .entry_rd   (entry_rd)
  );

  // Head age: restarts whenever the head changes or the FIFO is empty, so a
  // starved entry costs exactly one stall cycle.
  always_ff @(posedge clk) begin
    if (rst || pop || empty) begin
      wait_cnt <= '0;
    end else if (wait_cnt < CntW'(STARVE_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        mask = mask | rd_onehot(entry_rd[i]);
      end
    end
  end

  assign lu_ready_out     = !rst && !full;
  assign pipe_stall_out   = !rst && starved;
  assign pending_mask_out = rst ? 32'd0 : mask;
  assign rf_wr_out        = grant_fifo || grant_wb;
  assign rf_rd_out        = grant_wb ? wb_rd_in : head.rd;
  assign rf_data_out      = grant_wb ? wb_data_in : XLEN'(head.data);

  a_count_consistent : assert property (@(posedge clk) disable iff (rst)
    (32'(count) <= DEPTH) && (empty == (count == '0)));

endmodule
